// File: rtl/insn_encoder_loader.sv
// Packs instruction fields into 32-bit R/I/JI/JII words and streams them into
// instruction memory, one word per accepted request, from a session start address.
module insn_encoder_loader #(
  parameter int ADDR_W    = 12,
  parameter int MAX_WORDS = 4096
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_shamt,
  input  logic [4:0]        in_aluop,
  input  logic [16:0]       in_imm,
  input  logic [26:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   words,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W:0]   words_reg, words_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [31:0]       enc_word;

  localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W+1)'(MAX_WORDS);

  // Field packing by instruction kind; kinds 12-15 never reach the write path.
  always_comb begin
    enc_word = 32'h0;
    unique case (in_kind)
      4'd0:  enc_word = {5'b00000, in_rd, in_rs, in_rt, in_shamt, in_aluop, 2'b00};
      4'd1:  enc_word = {5'b00101, in_rd, in_rs, in_imm};
      4'd2:  enc_word = {5'b00111, in_rd, in_rs, in_imm};
      4'd3:  enc_word = {5'b01000, in_rd, in_rs, in_imm};
      4'd4:  enc_word = {5'b00010, in_rd, in_rs, in_imm};
      4'd5:  enc_word = {5'b00110, in_rd, in_rs, in_imm};
      4'd6:  enc_word = {5'b00001, in_target};
      4'd7:  enc_word = {5'b00011, in_target};
      4'd8:  enc_word = {5'b00100, in_rd, 22'h0};
      4'd9:  enc_word = {5'b10110, in_target};
      4'd10: enc_word = {5'b10101, in_target};
      4'd11: enc_word = {5'b01001, in_rd, in_rs, in_imm};
      default: enc_word = 32'h0;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    wr_ptr_next = wr_ptr_reg;
    words_next  = words_reg;
    we_next     = 1'b0;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    case (state_reg)
      S_RUN: begin
        if (in_valid) begin
          if (in_kind == 4'd15) begin
            state_next = S_DONE;
          end else if (in_kind >= 4'd12) begin
            state_next = S_ERR;
          end else begin
            we_next     = 1'b1;
            addr_next   = wr_ptr_reg;
            wdata_next  = enc_word;
            wr_ptr_next = wr_ptr_reg + ADDR_W'(1);
            words_next  = words_reg + (ADDR_W+1)'(1);
            // The final word is still written; the session closes on the same edge.
            if (words_next == LAST_COUNT) state_next = S_DONE;
          end
        end
      end
      default: begin
        if (start) begin
          state_next  = S_RUN;
          wr_ptr_next = start_addr;
          words_next  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      wr_ptr_reg <= '0;
      words_reg  <= '0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= 32'h0;
    end else begin
      state_reg  <= state_next;
      wr_ptr_reg <= wr_ptr_next;
      words_reg  <= words_next;
      we_reg     <= we_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
    end
  end

  assign in_ready   = (state_reg == S_RUN);
  assign imem_we    = we_reg;
  assign imem_addr  = addr_reg;
  assign imem_wdata = wdata_reg;
  assign words      = words_reg;
  assign done       = (state_reg == S_DONE);
  assign err        = (state_reg == S_ERR);

endmodule
